ibex_md_share_arb: RTL

Shares one multi-cycle multiplier/divider unit between `NumReq` requesters, e.g. the core EX stage and a tightly coupled accelerator port. The block latches one request, drives the unit's enable, select, operator and operand inputs until the unit reports a result, then returns the result to the requester that issued it. Grants are round-robin. The block sits between the requesters and the multiplier/divider unit, in place of a direct connection.

---
 rtl/ibex_pkg.sv | 26 ++
 rtl/ibex_rr_pick.sv | 29 ++
 rtl/ibex_md_share_arb.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared Ibex types, extended with the multiplier/divider share arbiter's
// state encoding and sizing constants.
package ibex_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL,
    MD_OP_MULH,
    MD_OP_DIV,
    MD_OP_REM
  } md_op_e;

  typedef enum logic [1:0] {
    MD_ARB_IDLE,
    MD_ARB_BUSY,
    MD_ARB_DRAIN,
    MD_ARB_RESP
  } md_arb_state_e;

  localparam int MdArbMaxReq = 4;
  localparam int MdArbIdxW   = $clog2(MdArbMaxReq);

  function automatic logic md_op_is_mult(md_op_e op);
    return (op == MD_OP_MULL) || (op == MD_OP_MULH);
  endfunction

endpackage

// File: rtl/ibex_rr_pick.sv
// Combinational round-robin pick: first valid requester at or after i_ptr,
// wrapping at NumReq. Returns a one-hot grant and its index.
module ibex_rr_pick import ibex_pkg::*; #(
  parameter int NumReq = 2
) (
  input  logic [NumReq-1:0]    i_valid,
  input  logic [MdArbIdxW-1:0] i_ptr,
  output logic [NumReq-1:0]    o_grant,
  output logic [MdArbIdxW-1:0] o_idx,
  output logic                 o_any
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    // k is the search distance from the pointer; smallest k wins
    for (int k = 0; k < NumReq; k++) begin
      for (int j = 0; j < NumReq; j++) begin
        if (!o_any && i_valid[j] && (((int'(i_ptr) + k) % NumReq) == j)) begin
          o_any      = 1'b1;
          o_grant[j] = 1'b1;
          o_idx      = MdArbIdxW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/ibex_md_share_arb.sv
// Shares one multi-cycle mult/div unit between NumReq requesters, round-robin.
// IBEX_MD_ARB_PERF_EN adds saturating grant and busy-cycle counters.
module ibex_md_share_arb import ibex_pkg::*; #(
  parameter int NumReq = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumReq-1:0]        req_valid_i,
  output logic [NumReq-1:0]        req_ready_o,
  input  md_op_e [NumReq-1:0]      req_op_i,
  input  logic [NumReq-1:0][1:0]   req_signed_mode_i,
  input  logic [NumReq-1:0][31:0]  req_op_a_i,
  input  logic [NumReq-1:0][31:0]  req_op_b_i,
  input  logic [NumReq-1:0]        req_kill_i,
  output logic [NumReq-1:0]        rsp_valid_o,
  input  logic [NumReq-1:0]        rsp_ready_i,
  output logic [31:0]              rsp_result_o,
  output logic                     md_mult_en_o,
  output logic                     md_div_en_o,
  output logic                     md_mult_sel_o,
  output logic                     md_div_sel_o,
  output md_op_e                   md_operator_o,
  output logic [1:0]               md_signed_mode_o,
  output logic [31:0]              md_op_a_o,
  output logic [31:0]              md_op_b_o,
  input  logic                     md_valid_i,
  input  logic [31:0]              md_result_i,
  output logic                     md_ready_id_o
`ifdef IBEX_MD_ARB_PERF_EN
  ,
  output logic [NumReq-1:0][31:0]  perf_grant_cnt_o,
  output logic [31:0]              perf_busy_cnt_o
`endif
);

  md_arb_state_e        r_state, w_state_n;
  logic [MdArbIdxW-1:0] r_rr_ptr, w_idx;
  logic [NumReq-1:0]    r_owner_oh, w_grant;
  logic                 w_any, w_hs, w_kill, w_rsp_hs, w_ready_id, w_active, w_is_mult;
  md_op_e               r_op, w_op;
  logic [1:0]           r_sm, w_sm;
  logic [31:0]          r_a, r_b, w_a, w_b, r_result;

  ibex_rr_pick #(.NumReq(NumReq)) u_pick (
    .i_valid (req_valid_i),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_kill   = |(req_kill_i & r_owner_oh);
  assign w_rsp_hs = |(rsp_ready_i & r_owner_oh);

  always_comb begin
    w_op = MD_OP_MULL;
    w_sm = '0;
    w_a  = '0;
    w_b  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (w_grant[i]) begin
        w_op = req_op_i[i];
        w_sm = req_signed_mode_i[i];
        w_a  = req_op_a_i[i];
        w_b  = req_op_b_i[i];
      end
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_hs       = 1'b0;
    w_ready_id = 1'b0;
    case (r_state)
      MD_ARB_IDLE: begin
        if (w_any) begin
          w_hs      = 1'b1;
          w_state_n = MD_ARB_BUSY;
        end
      end
      MD_ARB_BUSY: begin
        // kill beats a same-cycle result: the result is consumed and dropped
        if (w_kill) begin
          w_ready_id = md_valid_i;
          w_state_n  = md_valid_i ? MD_ARB_IDLE : MD_ARB_DRAIN;
        end else if (md_valid_i) begin
          w_ready_id = 1'b1;
          w_state_n  = MD_ARB_RESP;
        end
      end
      MD_ARB_DRAIN: begin
        if (md_valid_i) begin
          w_ready_id = 1'b1;
          w_state_n  = MD_ARB_IDLE;
        end
      end
      MD_ARB_RESP: begin
        if (w_kill || w_rsp_hs) w_state_n = MD_ARB_IDLE;
      end
      default: w_state_n = MD_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= MD_ARB_IDLE;
      r_rr_ptr   <= '0;
      r_owner_oh <= '0;
      r_op       <= MD_OP_MULL;
      r_sm       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_hs) begin
        r_owner_oh <= w_grant;
        r_op       <= w_op;
        r_sm       <= w_sm;
        r_a        <= w_a;
        r_b        <= w_b;
        r_rr_ptr   <= (w_idx == MdArbIdxW'(NumReq - 1)) ? '0 : w_idx + 1'b1;
      end
      if (r_state == MD_ARB_BUSY && md_valid_i && !w_kill) r_result <= md_result_i;
    end
  end

  // enables stay up through DRAIN: the unit cannot abort a started operation
  assign w_active         = (r_state == MD_ARB_BUSY) || (r_state == MD_ARB_DRAIN);
  assign w_is_mult        = md_op_is_mult(r_op);
  assign md_mult_en_o     = w_active & w_is_mult;
  assign md_mult_sel_o    = w_active & w_is_mult;
  assign md_div_en_o      = w_active & ~w_is_mult;
  assign md_div_sel_o     = w_active & ~w_is_mult;
  assign md_operator_o    = r_op;
  assign md_signed_mode_o = r_sm;
  assign md_op_a_o        = r_a;
  assign md_op_b_o        = r_b;
  assign md_ready_id_o    = w_ready_id;

  assign req_ready_o  = (r_state == MD_ARB_IDLE) ? w_grant : '0;
  assign rsp_valid_o  = (r_state == MD_ARB_RESP) ? r_owner_oh : '0;
  assign rsp_result_o = r_result;

`ifdef IBEX_MD_ARB_PERF_EN
  logic [NumReq-1:0][31:0] r_grant_cnt;
  logic [31:0]             r_busy_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_grant_cnt <= '0;
      r_busy_cnt  <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (req_ready_o[i] && (r_grant_cnt[i] != '1)) r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
      end
      if (w_active && (r_busy_cnt != '1)) r_busy_cnt <= r_busy_cnt + 32'd1;
    end
  end

  assign perf_grant_cnt_o = r_grant_cnt;
  assign perf_busy_cnt_o  = r_busy_cnt;
`endif

endmodule
